sectored_cache: RTL

SECTORED_CACHE -- requirements
Module: sectored_cache

---
 rtl/sectored_cache_pkg.sv | 42 ++++
 rtl/sectored_cache_lru.sv | 50 +++++
 rtl/sectored_cache.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sectored_cache_pkg.sv
// Purpose: shared FSM state type and geometry helpers for the sectored cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sectored_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_RESP,
    ST_FLUSH
  } state_t;

  // ceil(log2(v)); log2(1) = 0
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Keeps vector widths legal when a field degenerates to zero bits.
  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int num_sets(input int cache_size, input int line_size, input int ways);
    return cache_size / (line_size * ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int cache_size, input int line_size,
                               input int ways);
    return addr_w - log2(line_size) - log2(num_sets(cache_size, line_size, ways));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sectored_cache_lru.sv
// Purpose: per-set true-LRU age update and victim selection (pure combinational).
// Latency: 0 cycles.
// Backpressure: none; evaluated every cycle for the set under lookup.
// Ports: ages_in/ages_out packed per-way ages (way 0 in the LSBs), way_used = way holds
//        any valid sector, acc_way = way being touched, victim = replacement choice.
module sectored_cache_lru #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic [WAYS-1:0]       way_used,
  input  logic [AGE_W-1:0]      acc_way,
  output logic [WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]      victim
);

  logic [AGE_W-1:0] acc_age;
  logic             found_free;

  always_comb begin
    acc_age    = ages_in[acc_way*AGE_W +: AGE_W];
    ages_out   = ages_in;
    victim     = '0;
    found_free = 1'b0;

    // Touched way becomes youngest; only ways younger than it age by one,
    // so the set keeps a permutation of 0..WAYS-1.
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way) begin
        ages_out[w*AGE_W +: AGE_W] = '0;
      end else if (ages_in[w*AGE_W +: AGE_W] < acc_age) begin
        ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + 1'b1;
      end
    end

    // Scan downward so the lowest-index free way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_used[w]) begin
        victim     = AGE_W'(w);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_in[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/sectored_cache.sv
// Purpose: set-associative sectored cache tag model with true LRU and flush.
// Latency: rsp_valid 2 cycles after accept on a hit, 2+FILL_LATENCY on any miss.
// Backpressure: req_ready only in IDLE; responses are a one-cycle pulse, never stalled.
// Ports: req_valid/req_ready/req_addr request handshake, flush invalidate-all (IDLE only),
//        rsp_valid/rsp_hit/rsp_sector_miss/rsp_way response, total_* counters,
//        num_sets/sectors_per_line/tag_bits geometry constants.
// Option: define SECTORED_CACHE_STATS_EN to build the counters (tied to 0 otherwise).
module sectored_cache
  import sectored_cache_pkg::*;
#(
  parameter int CACHE_SIZE    = 8192,
  parameter int LINE_SIZE     = 32,
  parameter int SECTOR_SIZE   = 8,
  parameter int ASSOCIATIVITY = 4,
  parameter int ADDR_W        = 32,
  parameter int FILL_LATENCY  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic                                  flush,
  output logic                                  rsp_valid,
  output logic                                  rsp_hit,
  output logic                                  rsp_sector_miss,
  output logic [min1(log2(ASSOCIATIVITY))-1:0]  rsp_way,
  output logic [31:0]                           total_hits,
  output logic [31:0]                           total_line_misses,
  output logic [31:0]                           total_sector_misses,
  output logic [31:0]                           total_evictions,
  output logic [31:0]                           num_sets,
  output logic [31:0]                           sectors_per_line,
  output logic [31:0]                           tag_bits
);

  localparam int NUM_SETS = sectored_cache_pkg::num_sets(CACHE_SIZE, LINE_SIZE, ASSOCIATIVITY);
  localparam int SECTORS  = LINE_SIZE / SECTOR_SIZE;
  localparam int OFF_W    = log2(LINE_SIZE);
  localparam int SOFF_W   = log2(SECTOR_SIZE);
  localparam int TAG_W    = tag_w(ADDR_W, CACHE_SIZE, LINE_SIZE, ASSOCIATIVITY);
  localparam int IDX_W    = min1(log2(NUM_SETS));
  localparam int SEC_W    = min1(log2(SECTORS));
  localparam int WAY_W    = min1(log2(ASSOCIATIVITY));
  localparam int CNT_W    = min1(log2(FILL_LATENCY));

  assign num_sets         = 32'(NUM_SETS);
  assign sectors_per_line = 32'(SECTORS);
  assign tag_bits         = 32'(TAG_W);

  logic [TAG_W-1:0]               tag_mem [NUM_SETS][ASSOCIATIVITY];
  logic [SECTORS-1:0]             vld_mem [NUM_SETS][ASSOCIATIVITY];
  logic [ASSOCIATIVITY*WAY_W-1:0] age_mem [NUM_SETS];

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  fill_cnt;
  logic [WAY_W-1:0]  fill_way;
  logic              line_miss_q;
  logic [IDX_W-1:0]  flush_idx;

  // Field decode via shift/mask so degenerate (1-set / 1-sector) geometries stay legal.
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [SEC_W-1:0] sec;
  assign idx = IDX_W'((addr_q >> OFF_W) & ADDR_W'(NUM_SETS - 1));
  assign tag = TAG_W'(addr_q >> (ADDR_W - TAG_W));
  assign sec = SEC_W'((addr_q >> SOFF_W) & ADDR_W'(SECTORS - 1));

  logic                     hit_any;
  logic [WAY_W-1:0]         hit_way;
  logic [ASSOCIATIVITY-1:0] way_used;
  logic                     sec_vld;

  // A way with no valid sectors is treated as empty, so its stale tag never matches.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    way_used = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      way_used[w] = |vld_mem[idx][w];
      if (way_used[w] && tag_mem[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end
  assign sec_vld = vld_mem[idx][hit_way][sec];

  logic [ASSOCIATIVITY*WAY_W-1:0] ages_nxt;
  logic [WAY_W-1:0]               victim;
  logic [WAY_W-1:0]               acc_way;
  assign acc_way = (state == ST_FILL) ? fill_way : hit_way;

  sectored_cache_lru #(
    .WAYS  (ASSOCIATIVITY),
    .AGE_W (WAY_W)
  ) u_lru (
    .ages_in  (age_mem[idx]),
    .way_used (way_used),
    .acc_way  (acc_way),
    .ages_out (ages_nxt),
    .victim   (victim)
  );

  logic fill_last, lookup_hit, fill_done;
  assign fill_last  = (fill_cnt == CNT_W'(FILL_LATENCY - 1));
  assign lookup_hit = (state == ST_LOOKUP) && hit_any && sec_vld;
  assign fill_done  = (state == ST_FILL) && fill_last;

  always_comb begin
    state_n   = state;
    req_ready = (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (flush)          state_n = ST_FLUSH;
        else if (req_valid) state_n = ST_LOOKUP;
      end
      ST_LOOKUP: state_n = (hit_any && sec_vld) ? ST_RESP : ST_FILL;
      ST_FILL:   if (fill_last) state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      ST_FLUSH:  if (flush_idx == IDX_W'(NUM_SETS - 1)) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      fill_cnt        <= '0;
      fill_way        <= '0;
      line_miss_q     <= 1'b0;
      flush_idx       <= '0;
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_sector_miss <= 1'b0;
      rsp_way         <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          vld_mem[s][w]                 <= '0;
          age_mem[s][w*WAY_W +: WAY_W]  <= WAY_W'(w);
        end
      end
    end else begin
      state           <= state_n;
      // Response fields are registered on the edge entering RESP and cleared otherwise,
      // which makes them a one-cycle pulse and zero outside it.
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_sector_miss <= 1'b0;
      rsp_way         <= '0;
      case (state)
        ST_IDLE: begin
          flush_idx <= '0;
          if (!flush && req_valid) addr_q <= req_addr;
        end
        ST_LOOKUP: begin
          fill_cnt <= '0;
          if (hit_any && sec_vld) begin
            age_mem[idx] <= ages_nxt;
            rsp_valid    <= 1'b1;
            rsp_hit      <= 1'b1;
            rsp_way      <= hit_way;
          end else begin
            fill_way    <= hit_any ? hit_way : victim;
            line_miss_q <= !hit_any;
          end
        end
        ST_FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_last) begin
            age_mem[idx] <= ages_nxt;
            if (line_miss_q) begin
              tag_mem[idx][fill_way] <= tag;
              vld_mem[idx][fill_way] <= SECTORS'(1) << sec;
            end else begin
              vld_mem[idx][fill_way][sec] <= 1'b1;
            end
            rsp_valid       <= 1'b1;
            rsp_sector_miss <= !line_miss_q;
            rsp_way         <= fill_way;
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < ASSOCIATIVITY; w++) begin
            vld_mem[flush_idx][w]                <= '0;
            age_mem[flush_idx][w*WAY_W +: WAY_W] <= WAY_W'(w);
          end
          flush_idx <= flush_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SECTORED_CACHE_STATS_EN
  logic        evict_q;
  logic [31:0] hits_q, lmiss_q, smiss_q, evict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evict_q     <= 1'b0;
      hits_q      <= '0;
      lmiss_q     <= '0;
      smiss_q     <= '0;
      evict_cnt_q <= '0;
    end else begin
      // Victim occupancy must be captured before the fill overwrites it.
      if (state == ST_LOOKUP) evict_q <= !hit_any && way_used[victim];
      if (lookup_hit)                            hits_q      <= sat_inc(hits_q);
      if (fill_done && line_miss_q)              lmiss_q     <= sat_inc(lmiss_q);
      if (fill_done && !line_miss_q)             smiss_q     <= sat_inc(smiss_q);
      if (fill_done && line_miss_q && evict_q)   evict_cnt_q <= sat_inc(evict_cnt_q);
    end
  end

  assign total_hits          = hits_q;
  assign total_line_misses   = lmiss_q;
  assign total_sector_misses = smiss_q;
  assign total_evictions     = evict_cnt_q;
`else
  // lookup_hit / fill_done only feed the counters; fold them in so they stay referenced.
  logic stats_unused;
  assign stats_unused        = lookup_hit & fill_done;
  assign total_hits          = 32'd0 & {32{stats_unused}};
  assign total_line_misses   = 32'd0;
  assign total_sector_misses = 32'd0;
  assign total_evictions     = 32'd0;
`endif

endmodule
